ball_motion: RTL and testbench
==============================

# ball_motion

Per-ball kinematics block that consumes the velocity results of the hit controller (collision pulse plus new velocity), wall-hit flags and cue strikes, and owns the ball's position and velocity registers. Once per video frame it integrates velocity into a fixed-point position and applies friction. It feeds the ball's top-left position and current velocity back to the drawing logic and to the collision logic, closing the loop.

## Interface

Parameters:
- INIT_X, 100: reset top-left X (pixels, signed 11-bit range)
- INIT_Y, 100: reset top-left Y (pixels)
- FRAC_BITS, 6: velocity unit is 1/2^FRAC_BITS pixel per frame
- FRICTION_PERIOD, 4: frames between friction decrements (≥1)
- MAX_VEL, 511: velocity component saturation magnitude (≤1023)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- startOfFrame  in  1  one-cycle pulse per frame
- strikeValid  in  1  one-cycle pulse: load cue velocity
- strikeVelX, strikeVelY  in  11 signed  cue velocity
- collisionOccurred  in  1  one-cycle pulse from hit controller
- ballVelXIn, ballVelYIn  in  11 signed  post-collision velocity, valid with collisionOccurred
- hitLeft, hitRight, hitTop, hitBottom  in  1  wall contact flags (level or pulse)
- ballTopLeftPosX, ballTopLeftPosY  out  11 signed  integer part of position
- ballVelX, ballVelY  out  11 signed  current velocity
- moving  out  1  high when either velocity component ≠ 0

## Operation

- State: posX/posY, each 11+FRAC_BITS bits signed fixed point; velX/velY 11-bit signed; frameCnt counting 0..FRICTION_PERIOD-1.
- FSM: IDLE (velX=velY=0) and MOVING. IDLE→MOVING when the velocity register becomes non-zero; MOVING→IDLE when both components reach 0. `moving` = (state==MOVING), registered.
- Velocity next-value priority (one source per cycle):
  1. strikeValid: load strikeVel*.
  2. collisionOccurred: load ballVel*In.
  3. wall flags: hitLeft → velX = |velX|; hitRight → velX = -|velX|; hitTop → velY = |velY|; hitBottom → velY = -|velY|. Idempotent; both flags of one axis asserted → that axis is unchanged. X and Y axes are handled independently.
  4. startOfFrame with frameCnt == FRICTION_PERIOD-1: each non-zero component moves 1 toward 0.
  5. Otherwise hold.
- Every loaded value is saturated to ±MAX_VEL; -1024 maps to -MAX_VEL.
- Position: on startOfFrame, pos += sign-extended vel (old register value, before any same-cycle velocity change). Sum is saturated to the representable range, integer part [-1024, 1023]; no wrap-around.
- frameCnt advances on every startOfFrame regardless of velocity source and wraps to 0. A friction step pre-empted by a higher-priority source is skipped, not deferred.
- Outputs ballTopLeftPos* = pos >>> FRAC_BITS, using arithmetic truncation toward -inf.

## Timing

- All outputs are registered. Reset values: pos = INIT_X/INIT_Y with fractional part 0, vel = 0, frameCnt = 0, moving = 0, state = IDLE.
- Velocity change is visible on ballVel* 1 cycle after the qualifying input cycle.
- Position change is visible 1 cycle after startOfFrame.
- `moving` lags the velocity register by 1 cycle.
- startOfFrame together with collisionOccurred in the same cycle: the position integrates the old velocity and the velocity takes the collision value.
- Reset asserted mid-frame overrides all inputs in that cycle. Inputs arriving during reset are dropped.
- No handshake back-pressure: every pulse is consumed in its cycle.

## Test plan

- Reset (INIT_X=100, INIT_Y=100), then no stimulus for 10 frames -> pos (100,100), vel (0,0), moving=0 throughout.
- Strike vel (64,-128), FRICTION_PERIOD=4, 4 frames -> X: 101,102,103,104; Y: 98,96,94,92. After frame 4 vel = (63,-127), moving=1.
- Strike (1,0), then 4 frames -> friction reaches vel 0 at frame 4, moving falls 1 cycle later, and pos X stays at the value reached with 1/64 px steps (100).
- Strike (20,0), hitRight held for 3 cycles -> vel X = -20 after the first cycle and stays -20. hitLeft+hitRight together -> vel unchanged.
- collisionOccurred with ballVelIn (-300,700) coincident with startOfFrame, old vel (64,0) -> pos X +1, new vel (-300,511) saturated.
- Strike (511,511) at INIT 1020 for several frames -> integer pos saturates at 1023, no wrap. Assert reset mid-run -> next cycle pos (INIT_X,INIT_Y), vel 0.

Source files
------------

// File: rtl/ball_motion.sv
// Per-ball kinematics: owns fixed-point position and velocity, integrates once per
// frame, applies periodic friction, and folds in cue strikes, collisions and wall hits.
module ball_motion #(
  parameter int INIT_X          = 100,
  parameter int INIT_Y          = 100,
  parameter int FRAC_BITS       = 6,
  parameter int FRICTION_PERIOD = 4,
  parameter int MAX_VEL         = 511
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               strikeValid,
  input  logic signed [10:0] strikeVelX,
  input  logic signed [10:0] strikeVelY,
  input  logic               collisionOccurred,
  input  logic signed [10:0] ballVelXIn,
  input  logic signed [10:0] ballVelYIn,
  input  logic               hitLeft,
  input  logic               hitRight,
  input  logic               hitTop,
  input  logic               hitBottom,
  output logic signed [10:0] ballTopLeftPosX,
  output logic signed [10:0] ballTopLeftPosY,
  output logic signed [10:0] ballVelX,
  output logic signed [10:0] ballVelY,
  output logic               moving
);

  localparam int PW = 11 + FRAC_BITS;
  localparam int SW = PW + 1;
  localparam int CW = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

  localparam logic [CW-1:0]        LAST_FRAME = CW'(FRICTION_PERIOD - 1);
  localparam logic signed [10:0]   VEL_MAX    = 11'(MAX_VEL);
  localparam logic signed [PW-1:0] INIT_PX    = PW'(INIT_X) <<< FRAC_BITS;
  localparam logic signed [PW-1:0] INIT_PY    = PW'(INIT_Y) <<< FRAC_BITS;
  localparam logic signed [PW-1:0] POS_MAX    = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] POS_MIN    = {1'b1, {(PW-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } state_t;

  state_t               state_r, state_n;
  logic signed [PW-1:0] pos_x_r, pos_y_r, pos_x_n, pos_y_n;
  logic signed [10:0]   vel_x_r, vel_y_r, vel_x_n, vel_y_n;
  logic [CW-1:0]        frame_cnt_r, frame_cnt_n;
  logic                 moving_r;
  logic                 wall_any_s;
  logic                 friction_s;

  function automatic logic signed [10:0] sat_vel(input logic signed [10:0] v);
    logic signed [10:0] r;
    if (v > VEL_MAX) begin
      r = VEL_MAX;
    end else if (v < -VEL_MAX) begin
      r = -VEL_MAX;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic signed [10:0] abs_vel(input logic signed [10:0] v);
    return (v < 11'sd0) ? -v : v;
  endfunction

  function automatic logic signed [10:0] toward_zero(input logic signed [10:0] v);
    logic signed [10:0] r;
    if (v > 11'sd0) begin
      r = v - 11'sd1;
    end else if (v < 11'sd0) begin
      r = v + 11'sd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // A wall only ever points the component away from itself; opposing walls cancel.
  function automatic logic signed [10:0] reflect(input logic signed [10:0] v,
                                                 input logic to_pos,
                                                 input logic to_neg);
    logic signed [10:0] r;
    if (to_pos && !to_neg) begin
      r = sat_vel(abs_vel(v));
    end else if (to_neg && !to_pos) begin
      r = sat_vel(-abs_vel(v));
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic signed [PW-1:0] integrate(input logic signed [PW-1:0] p,
                                                     input logic signed [10:0] v);
    logic signed [SW-1:0] sum;
    logic signed [PW-1:0] r;
    sum = SW'(p) + SW'(v);
    if (sum[SW-1] != sum[SW-2]) begin
      r = sum[SW-1] ? POS_MIN : POS_MAX;
    end else begin
      r = sum[PW-1:0];
    end
    return r;
  endfunction

  // Velocity source selection, one source per cycle in fixed priority.
  always_comb begin
    vel_x_n    = vel_x_r;
    vel_y_n    = vel_y_r;
    wall_any_s = hitLeft | hitRight | hitTop | hitBottom;
    friction_s = startOfFrame && (frame_cnt_r == LAST_FRAME);
    if (strikeValid) begin
      vel_x_n = sat_vel(strikeVelX);
      vel_y_n = sat_vel(strikeVelY);
    end else if (collisionOccurred) begin
      vel_x_n = sat_vel(ballVelXIn);
      vel_y_n = sat_vel(ballVelYIn);
    end else if (wall_any_s) begin
      vel_x_n = reflect(vel_x_r, hitLeft, hitRight);
      vel_y_n = reflect(vel_y_r, hitTop, hitBottom);
    end else if (friction_s) begin
      vel_x_n = toward_zero(vel_x_r);
      vel_y_n = toward_zero(vel_y_r);
    end else begin
      vel_x_n = vel_x_r;
      vel_y_n = vel_y_r;
    end
  end

  // Frame integration uses the velocity held before this cycle's update.
  always_comb begin
    pos_x_n     = pos_x_r;
    pos_y_n     = pos_y_r;
    frame_cnt_n = frame_cnt_r;
    if (startOfFrame) begin
      pos_x_n     = integrate(pos_x_r, vel_x_r);
      pos_y_n     = integrate(pos_y_r, vel_y_r);
      frame_cnt_n = (frame_cnt_r == LAST_FRAME) ? {CW{1'b0}} : frame_cnt_r + CW'(1);
    end else begin
      pos_x_n     = pos_x_r;
      pos_y_n     = pos_y_r;
      frame_cnt_n = frame_cnt_r;
    end
  end

  // Motion state follows the velocity register one cycle later.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if ((vel_x_r != 11'sd0) || (vel_y_r != 11'sd0)) begin
          state_n = MOVING;
        end else begin
          state_n = IDLE;
        end
      end
      MOVING: begin
        if ((vel_x_r == 11'sd0) && (vel_y_r == 11'sd0)) begin
          state_n = IDLE;
        end else begin
          state_n = MOVING;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers; reset overrides every input in its cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x_r     <= INIT_PX;
      pos_y_r     <= INIT_PY;
      vel_x_r     <= 11'sd0;
      vel_y_r     <= 11'sd0;
      frame_cnt_r <= {CW{1'b0}};
      state_r     <= IDLE;
      moving_r    <= 1'b0;
    end else begin
      pos_x_r     <= pos_x_n;
      pos_y_r     <= pos_y_n;
      vel_x_r     <= vel_x_n;
      vel_y_r     <= vel_y_n;
      frame_cnt_r <= frame_cnt_n;
      state_r     <= state_n;
      moving_r    <= (state_n == MOVING);
    end
  end

  assign ballTopLeftPosX = pos_x_r[PW-1:FRAC_BITS];
  assign ballTopLeftPosY = pos_y_r[PW-1:FRAC_BITS];
  assign ballVelX        = vel_x_r;
  assign ballVelY        = vel_y_r;
  assign moving          = moving_r;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with hand-computed expectations (defaults:
// INIT 100/100, FRAC_BITS 6, FRICTION_PERIOD 4, MAX_VEL 511).
module tb_ball_motion;

  logic               clk = 1'b0;
  logic               reset;
  logic               startOfFrame;
  logic               strikeValid;
  logic signed [10:0] strikeVelX, strikeVelY;
  logic               collisionOccurred;
  logic signed [10:0] ballVelXIn, ballVelYIn;
  logic               hitLeft, hitRight, hitTop, hitBottom;
  logic signed [10:0] ballTopLeftPosX, ballTopLeftPosY;
  logic signed [10:0] ballVelX, ballVelY;
  logic               moving;

  int n_compared   = 0;
  int n_mismatched = 0;

  ball_motion dut (
    .clk               (clk),
    .reset             (reset),
    .startOfFrame      (startOfFrame),
    .strikeValid       (strikeValid),
    .strikeVelX        (strikeVelX),
    .strikeVelY        (strikeVelY),
    .collisionOccurred (collisionOccurred),
    .ballVelXIn        (ballVelXIn),
    .ballVelYIn        (ballVelYIn),
    .hitLeft           (hitLeft),
    .hitRight          (hitRight),
    .hitTop            (hitTop),
    .hitBottom         (hitBottom),
    .ballTopLeftPosX   (ballTopLeftPosX),
    .ballTopLeftPosY   (ballTopLeftPosY),
    .ballVelX          (ballVelX),
    .ballVelY          (ballVelY),
    .moving            (moving)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set before this take effect on that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic strike(input int vx, input int vy);
    strikeVelX  = 11'(vx);
    strikeVelY  = 11'(vy);
    strikeValid = 1'b1;
    tick();
    strikeValid = 1'b0;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    reset = 1'b0; startOfFrame = 1'b0; strikeValid = 1'b0;
    strikeVelX = 11'sd0; strikeVelY = 11'sd0;
    collisionOccurred = 1'b0; ballVelXIn = 11'sd0; ballVelYIn = 11'sd0;
    hitLeft = 1'b0; hitRight = 1'b0; hitTop = 1'b0; hitBottom = 1'b0;
    #2;

    // Reset state and idle frames
    do_reset();
    check("rst_posx", ballTopLeftPosX, 100);
    check("rst_posy", ballTopLeftPosY, 100);
    check("rst_velx", ballVelX, 0);
    check("rst_vely", ballVelY, 0);
    check("rst_moving", moving, 0);
    for (int i = 0; i < 10; i++) begin
      frame();
      check("idle_posx", ballTopLeftPosX, 100);
      check("idle_posy", ballTopLeftPosY, 100);
      check("idle_moving", moving, 0);
    end

    // Strike (64,-128) and four frames with friction on the fourth
    do_reset();
    strike(64, -128);
    check("s1_velx", ballVelX, 64);
    check("s1_vely", ballVelY, -128);
    check("s1_moving_lag", moving, 0);
    for (int i = 1; i <= 4; i++) begin
      frame();
      check("s1_posx", ballTopLeftPosX, 100 + i);
      check("s1_posy", ballTopLeftPosY, 100 - 2 * i);
    end
    check("s1_velx_fric", ballVelX, 63);
    check("s1_vely_fric", ballVelY, -127);
    check("s1_moving", moving, 1);

    // Strike (1,0): friction stops the ball at frame 4
    do_reset();
    strike(1, 0);
    for (int i = 0; i < 4; i++) frame();
    check("s2_velx", ballVelX, 0);
    check("s2_moving_lag", moving, 1);
    check("s2_posx", ballTopLeftPosX, 100);
    tick();
    check("s2_moving_fall", moving, 0);

    // Wall reflections
    do_reset();
    strike(20, -30);
    hitRight = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wall_right_x", ballVelX, -20);
      check("wall_right_y", ballVelY, -30);
    end
    hitLeft = 1'b1;
    tick();
    check("wall_both_x", ballVelX, -20);
    hitRight = 1'b0;
    tick();
    check("wall_left_x", ballVelX, 20);
    hitLeft = 1'b0;
    hitTop  = 1'b1;
    tick();
    hitTop  = 1'b0;
    check("wall_top_y", ballVelY, 30);
    check("wall_top_x", ballVelX, 20);

    // Collision coincident with a frame, saturated load
    do_reset();
    strike(64, 0);
    collisionOccurred = 1'b1;
    ballVelXIn = -11'sd300;
    ballVelYIn = 11'sd700;
    frame();
    collisionOccurred = 1'b0;
    check("col_posx", ballTopLeftPosX, 101);
    check("col_posy", ballTopLeftPosY, 100);
    check("col_velx", ballVelX, -300);
    check("col_vely", ballVelY, 511);

    // Strike wins over collision; -1024 saturates to -MAX_VEL
    collisionOccurred = 1'b1;
    strike(-1024, 600);
    collisionOccurred = 1'b0;
    check("prio_velx", ballVelX, -511);
    check("prio_vely", ballVelY, 511);

    // Position saturation at the top of the range
    do_reset();
    for (int n = 1; n <= 120; n++) begin
      strike(511, 511);
      frame();
      if (n == 115) begin
        check("sat_posx_115", ballTopLeftPosX, 1018);
        check("sat_posy_115", ballTopLeftPosY, 1018);
      end
    end
    check("sat_posx", ballTopLeftPosX, 1023);
    check("sat_posy", ballTopLeftPosY, 1023);
    check("sat_moving", moving, 1);

    // Reset mid-run overrides coincident inputs
    reset        = 1'b1;
    strikeValid  = 1'b1;
    startOfFrame = 1'b1;
    tick();
    reset        = 1'b0;
    strikeValid  = 1'b0;
    startOfFrame = 1'b0;
    check("mid_rst_posx", ballTopLeftPosX, 100);
    check("mid_rst_posy", ballTopLeftPosY, 100);
    check("mid_rst_velx", ballVelX, 0);
    check("mid_rst_vely", ballVelY, 0);
    check("mid_rst_moving", moving, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
